spi_master_ctrl: RTL

//  SPI master that drives the SPI slave/single-port-RAM subsystem from a host-side command port.
//  - Accepts 10-bit command words {cmd[1:0], payload[7:0]} via a valid/ready handshake.
//  - Serialises each command onto MOSI within an SS_n-low frame.
//  - For read-data commands, collects the 8-bit reply from MISO and returns it on rd_data.
//  - Shares the system clock with the slave; no separate SCLK is generated.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_shift_reg.sv | 47 ++++
 rtl/spi_master_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master and the SPI slave/RAM subsystem.
//   - Command codes carried in bits [9:8] of each command word.
//   - FSM state encoding used by the master controller.
//   - max4: constant helper used to size the shared down-counter.
// ---------------------------------------------------------------------------
package spi_pkg;

    // Command codes; bit 1 doubles as the read/write flag sent on the wire.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_FLAG  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TURN  = 3'd4,
        ST_RECV  = 3'd5,
        ST_GAP   = 3'd6
    } spi_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
// Combined parallel-in/serial-out and serial-in/parallel-out shift register.
// The same register carries the outgoing command (MSB first) and, once it
// has been shifted out, collects the incoming reply at the LSB end.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   load        load load_data (has priority over shift)
//   load_data   W-bit parallel word
//   shift       shift left by one, serial_in enters at the LSB
//   serial_in   bit shifted in at the LSB
//   serial_out  current MSB
//   rx_next     low RX_W bits the register will hold after the next shift,
//               so a completed reply can be captured on its final sample edge
// ---------------------------------------------------------------------------
module spi_shift_reg #(
    parameter int W    = 10,
    parameter int RX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [W-1:0]    load_data,
    input  logic            shift,
    input  logic            serial_in,
    output logic            serial_out,
    output logic [RX_W-1:0] rx_next
);

    logic [W-1:0] sr;
    logic [W-1:0] sr_shifted;

    assign sr_shifted = {sr[W-2:0], serial_in};
    assign serial_out = sr[W-1];
    assign rx_next    = sr_shifted[RX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= sr_shifted;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// SPI master driving the slave/RAM subsystem from a host command port. Each
// accepted command {cmd[1:0], payload} is sent in an SS_n-low frame: lead
// cycles, a flag bit (cmd[1]), then the full command word MSB first. RD_DATA
// frames continue with a turnaround and DATA_W MISO samples, and the
// collected byte is presented on rd_data with a one-cycle rd_valid pulse.
// Frames are separated by GAP_CYCLES of SS_n high plus one IDLE cycle.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   cmd_valid   host command present
//   cmd_ready   command accepted on this edge if cmd_valid (IDLE only)
//   cmd_data    [DATA_W+1:DATA_W] command code, [DATA_W-1:0] payload
//   busy        frame or gap in progress
//   rd_valid    one-cycle pulse, rd_data updated
//   rd_data     last byte returned by an RD_DATA command
//   SS_n        slave select, active-low
//   MOSI        serial data to slave, MSB first
//   MISO        serial data from slave, MSB first
// ---------------------------------------------------------------------------
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int LEAD_CYCLES   = 1,
    parameter int RD_TURNAROUND = 1,
    parameter int GAP_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W+1:0] cmd_data,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_MAX = max4(LEAD_CYCLES, RD_TURNAROUND, GAP_CYCLES, FRAME_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    spi_state_t        state;
    spi_state_t        next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_load;
    logic [1:0]        cmd_q;
    logic              accept;
    logic              sr_shift;
    logic              sr_in;
    logic              sr_out;
    logic              recv_done;
    logic [DATA_W-1:0] rx_next;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign recv_done = (state == ST_RECV) && (cnt == '0);

    // Wire outputs are decoded straight from flops, so they carry no
    // combinational path from any input and come out of reset idle.
    assign SS_n = (state == ST_IDLE) || (state == ST_GAP);
    assign MOSI = ((state == ST_FLAG) || (state == ST_SHIFT)) && sr_out;

    // The register shifts through the whole command during SHIFT and keeps
    // shifting during RECV; MISO is gated so nothing from outside RECV
    // (including X) can reach the register.
    assign sr_shift = (state == ST_SHIFT) || (state == ST_RECV);
    assign sr_in    = (state == ST_RECV) ? MISO : 1'b0;

    spi_shift_reg #(
        .W    (FRAME_W),
        .RX_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_data  (cmd_data),
        .shift      (sr_shift),
        .serial_in  (sr_in),
        .serial_out (sr_out),
        .rx_next    (rx_next)
    );

    // Next-state logic plus the reload value for the shared counter. Each
    // timed state is entered with (duration - 1) and leaves when the count
    // reaches zero; zero-length LEAD/TURN/GAP phases are skipped entirely.
    always_comb begin
        next_state = state;
        cnt_load   = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    next_state = (LEAD_CYCLES > 0) ? ST_LEAD : ST_FLAG;
                end
            end
            ST_LEAD: begin
                if (cnt == '0) next_state = ST_FLAG;
            end
            ST_FLAG: begin
                next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt == '0) begin
                    if (cmd_q == CMD_RD_DATA) begin
                        next_state = (RD_TURNAROUND > 0) ? ST_TURN : ST_RECV;
                    end else begin
                        next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
            end
            ST_TURN: begin
                if (cnt == '0) next_state = ST_RECV;
            end
            ST_RECV: begin
                if (cnt == '0) next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (cnt == '0) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        case (next_state)
            ST_LEAD:  cnt_load = CNT_W'(LEAD_CYCLES - 1);
            ST_SHIFT: cnt_load = CNT_W'(FRAME_W - 1);
            ST_TURN:  cnt_load = CNT_W'(RD_TURNAROUND - 1);
            ST_RECV:  cnt_load = CNT_W'(DATA_W - 1);
            ST_GAP:   cnt_load = CNT_W'(GAP_CYCLES - 1);
            default:  cnt_load = '0;
        endcase
    end

    // State register, shared down-counter and latched command code. The
    // code is kept separately because the shift register loses it while
    // the command is being sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cmd_q <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= cnt_load;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (accept) begin
                cmd_q <= cmd_data[DATA_W+1:DATA_W];
            end
        end
    end

    // The last MISO sample is taken on the RECV->GAP edge, so the reply is
    // captured from the register's post-shift value on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= recv_done;
            if (recv_done) begin
                rd_data <= rx_next;
            end
        end
    end

endmodule
